byte_unit: RTL and testbench
============================

Name: byte_unit

Overview:
- Load-data formatting unit for the RV32I pipeline, in the memory/writeback path.
- Takes a raw 32-bit word and extracts a byte, halfword or full word from its low bits, with sign or zero extension selected by `sel`.
- Drives the result out of a register, one clock after sampling.

Parameters:
- DATA_WIDTH, 32, datapath width of in_data/out_data. Only 32 is supported; other values are a synthesis-time error.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous and active-high; clears the output register.
- in_data  input  DATA_WIDTH  raw data word; the selected field is always taken from the least-significant bits.
- sel  input  2  format select: 00 = signed byte, 01 = signed halfword, 10 = word, 11 = unsigned byte.
- out_data  output  DATA_WIDTH  formatted, extended result (registered).

Behaviour:
- Single clock domain; one output register; no handshake. A new sel/in_data pair is accepted every cycle.
- Reset:
  - rst=1 forces out_data to 0 immediately, without waiting for a clock edge.
  - out_data holds 0 for as long as rst stays high.
  - On the first rising clk edge after rst deasserts, the current inputs are registered.
  - Asserting rst between edges discards the pending result.
- Latency: exactly 1 cycle. out_data at edge N+1 reflects the sel/in_data sampled at edge N.
- Combinational next value, by sel:
  - 00 (LB): {{24{in_data[7]}}, in_data[7:0]}, sign-extended byte.
  - 01 (LH): {{16{in_data[15]}}, in_data[15:0]}, sign-extended halfword.
  - 10 (LW): in_data unchanged.
  - 11 (LBU): {24'b0, in_data[7:0]}, zero-extended byte.
- Unused upper input bits (31:8 for byte modes, 31:16 for halfword) have no effect on the result.
- sel is fully decoded, so there are no illegal values. An X/Z on sel drives out_data to 0 in simulation; synthesis is don't-care.
- Boundary cases:
  - Sign bit exactly 1 (0x80 byte, 0x8000 halfword) must produce full one-extension.
  - All-ones input:
    - sel=00 → 0xFFFFFFFF
    - sel=01 → 0xFFFFFFFF
    - sel=11 → 0x000000FF
- sel and in_data changing together in the same cycle is the normal case; both are sampled at the same edge.
- No internal state beyond the output register. Behaviour is independent of input history.

Test Plan:
- Reset: assert rst mid-cycle while out_data = 0x12345678 → out_data becomes 0 before the next edge and stays 0 while rst=1; deassert, apply sel=10, in_data=0xCAFEBABE → 0xCAFEBABE one edge later.
- Byte sign: in_data=0xAABBCC80, sel=00 → 0xFFFFFF80; sel=11 → 0x00000080; in_data=0xFFFFFF7F, sel=00 → 0x0000007F.
- Halfword sign: in_data=0x00008000, sel=01 → 0xFFFF8000; in_data=0xFFFF7FFF, sel=01 → 0x00007FFF.
- Word pass-through and latency:
  - Apply back-to-back sel=10 with in_data 0x00000001, 0x80000000, 0xFFFFFFFF on consecutive edges.
  - Required: identical values appear on out_data one cycle later, in order.
- Randomised mode sweep:
  - 100 cycles of random sel and in_data, one new pair every cycle.
  - Required: every out_data equals a reference-model result for the previous cycle's inputs, and all four sel codes are hit.
- All-ones/all-zeros: in_data=0xFFFFFFFF through sel=00/01/10/11 → 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFF, 0x000000FF; in_data=0 → 0 for every sel.

Source files
------------

// File: rtl/byte_unit.sv
// byte_unit: load-data formatting for the RV32I memory/writeback path.
//
// Takes a raw word and extracts a byte, halfword or full word from its
// least-significant bits. The field is sign- or zero-extended according to
// sel. The result comes out of a register one clock after sampling.
//
// Ports:
//   clk       in   1           system clock, rising edge active
//   rst       in   1           asynchronous active-high reset, clears out_data
//   in_data   in   DATA_WIDTH  raw data word (field taken from the low bits)
//   sel       in   2           00 = LB, 01 = LH, 10 = LW, 11 = LBU
//   out_data  out  DATA_WIDTH  formatted, extended result (registered)
//
// There is no handshake. A new sel/in_data pair is accepted on every rising
// edge, and out_data reflects the pair sampled one edge earlier.
module byte_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            sel,
  output logic [DATA_WIDTH-1:0] out_data
);

  // The extension widths below are written for a 32-bit word only.
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("byte_unit: only DATA_WIDTH = 32 is supported");
  end

  localparam logic [1:0] SEL_LB  = 2'b00;
  localparam logic [1:0] SEL_LH  = 2'b01;
  localparam logic [1:0] SEL_LW  = 2'b10;
  localparam logic [1:0] SEL_LBU = 2'b11;

  logic [DATA_WIDTH-1:0] next_data;

  // An X/Z on sel falls through to the default, so it gives zero in simulation.
  always_comb begin
    next_data = '0;
    case (sel)
      SEL_LB:  next_data = {{24{in_data[7]}}, in_data[7:0]};
      SEL_LH:  next_data = {{16{in_data[15]}}, in_data[15:0]};
      SEL_LW:  next_data = in_data;
      SEL_LBU: next_data = {24'b0, in_data[7:0]};
      default: next_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else begin
      out_data <= next_data;
    end
  end

endmodule

// File: tb/tb_byte_unit.sv
// Testbench for byte_unit.
// A driver pushes the expected result of each sampled pair into exp_q.
// A monitor pops from exp_q and compares on the falling edge after the
// rising edge that registered the pair.
module tb_byte_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic [1:0]   sel;
  logic [W-1:0] out_data;

  // Marks that the pair currently on the inputs has an expected value queued.
  logic         stim_valid;

  logic [W-1:0] exp_q[$];
  logic [1:0]   sel_q[$];
  int           checks;
  int           errors;
  bit [3:0]     sel_hit;

  byte_unit #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .sel      (sel),
    .out_data (out_data)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_fmt(input logic [1:0] s, input logic [W-1:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[7:0];
    h = d[15:0];
    case (s)
      2'b00:   ref_fmt = W'(b);
      2'b01:   ref_fmt = W'(h);
      2'b10:   ref_fmt = d;
      default: ref_fmt = {24'h000000, d[7:0]};
    endcase
  endfunction

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one pair on the falling edge; optionally queue its expected result.
  task automatic drive(input logic [1:0] s, input logic [W-1:0] d,
                       input bit push, input logic [W-1:0] exp);
    @(negedge clk);
    sel        = s;
    in_data    = d;
    stim_valid = push;
    if (push) begin
      exp_q.push_back(exp);
      sel_q.push_back(s);
    end
  endtask

  task automatic apply(input logic [1:0] s, input logic [W-1:0] d, input logic [W-1:0] exp);
    drive(s, d, 1'b1, exp);
  endtask

  task automatic idle();
    @(negedge clk);
    stim_valid = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit          cap;
    logic [W-1:0] e;
    logic [1:0]   s;
    forever begin
      @(posedge clk);
      cap = stim_valid && !rst;
      @(negedge clk);
      if (cap) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got %08h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          s = sel_q.pop_front();
          sel_hit[s] = 1'b1;
          check("scoreboard", out_data, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [1:0]   rs;
    logic [W-1:0] rd;
    int           budget;

    checks     = 0;
    errors     = 0;
    sel_hit    = '0;
    stim_valid = 1'b0;
    sel        = 2'b00;
    in_data    = '0;
    rst        = 1'b1;

    repeat (2) @(posedge clk);
    #1 check("reset_state", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-cycle, discarding a pending value.
    apply(2'b10, 32'h12345678, 32'h12345678);
    drive(2'b10, 32'hDEADBEEF, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1 check("rst_async", out_data, 32'h0);
    @(posedge clk);
    #1 check("rst_hold", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    apply(2'b10, 32'hCAFEBABE, 32'hCAFEBABE);

    // Byte sign / zero extension.
    apply(2'b00, 32'hAABBCC80, 32'hFFFFFF80);
    apply(2'b11, 32'hAABBCC80, 32'h00000080);
    apply(2'b00, 32'hFFFFFF7F, 32'h0000007F);

    // Halfword sign extension.
    apply(2'b01, 32'h00008000, 32'hFFFF8000);
    apply(2'b01, 32'hFFFF7FFF, 32'h00007FFF);

    // Word pass-through, back to back.
    apply(2'b10, 32'h00000001, 32'h00000001);
    apply(2'b10, 32'h80000000, 32'h80000000);
    apply(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // All-ones and all-zeros through every mode.
    apply(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    apply(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    apply(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
    apply(2'b11, 32'hFFFFFFFF, 32'h000000FF);
    apply(2'b00, 32'h00000000, 32'h00000000);
    apply(2'b01, 32'h00000000, 32'h00000000);
    apply(2'b10, 32'h00000000, 32'h00000000);
    apply(2'b11, 32'h00000000, 32'h00000000);

    // Upper bits must not leak into narrow modes.
    apply(2'b01, 32'h5A5A1234, 32'h00001234);
    apply(2'b11, 32'h123456F0, 32'h000000F0);

    // Random sweep, one new pair per cycle.
    sel_hit = '0;
    for (int i = 0; i < 100; i++) begin
      rs = (i < 4) ? 2'(i) : 2'($urandom_range(0, 3));
      rd = $urandom();
      apply(rs, rd, ref_fmt(rs, rd));
    end
    idle();

    // Drain the scoreboard within a bounded number of cycles.
    budget = 10;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (sel_hit != 4'hF) begin
      errors++;
      $display("FAIL sel_coverage: got %04b expected 1111", sel_hit);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
